// File: rtl/gate_vector_checker.sv
// Purpose: on-chip stimulus/response checker for a 2-input combinational gate.
//          Walks {x,y} through 00,10,11,01, samples z after a settle window and
//          compares it against the EXPECTED truth table.
// Latency: done pulses 1 + 4*(SETTLE_CYCLES+1) cycles after start is accepted.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, rst        rising-edge clock, synchronous active-high reset
//   start           run request (IDLE only)
//   z               observed DUT output
//   x, y            registered DUT inputs
//   busy            high in SETTLE, SAMPLE and DONE
//   done            one-cycle end-of-run pulse
//   pass            1 iff all four vectors matched; valid from done onward
//   err_count       number of mismatching vectors (0..4)
//   fail_mask       bit[{x,y}] set for each mismatching vector
module gate_vector_checker #(
    parameter int          SETTLE_CYCLES = 2,
    parameter logic [3:0]  EXPECTED      = 4'b1110
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       z,
    output logic       x,
    output logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_mask
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("gate_vector_checker: SETTLE_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [1:0] step;
    logic [3:0] cnt;

    logic [1:0] idx;
    logic       mismatch;
    logic [2:0] next_err;

    // Gray-ordered vector table: only one input toggles between steps.
    function automatic logic [1:0] vec_of(input logic [1:0] s);
        logic [1:0] v;
        case (s)
            2'd0:    v = 2'b00;
            2'd1:    v = 2'b10;
            2'd2:    v = 2'b11;
            default: v = 2'b01;
        endcase
        return v;
    endfunction

    assign idx      = {x, y};
    // Case inequality so an X/Z on z is reported as a mismatch in simulation.
    assign mismatch = (z !== EXPECTED[idx]);
    assign next_err = err_count + {2'b00, mismatch};

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            x         <= 1'b0;
            y         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_mask <= 4'd0;
            step      <= 2'd0;
            cnt       <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    x    <= 1'b0;
                    y    <= 1'b0;
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        err_count <= 3'd0;
                        fail_mask <= 4'd0;
                        pass      <= 1'b0;
                        step      <= 2'd0;
                        {x, y}    <= vec_of(2'd0);
                        cnt       <= 4'd0;
                        busy      <= 1'b1;
                        state     <= SETTLE;
                    end
                end
                SETTLE: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == CNT_LAST) begin
                        state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    if (mismatch) begin
                        err_count      <= next_err;
                        fail_mask[idx] <= 1'b1;
                    end
                    if (step == 2'd3) begin
                        // Final compare: pass uses the count including this vector.
                        pass   <= (next_err == 3'd0);
                        done   <= 1'b1;
                        {x, y} <= 2'b00;
                        state  <= DONE;
                    end else begin
                        step   <= step + 2'd1;
                        {x, y} <= vec_of(step + 2'd1);
                        cnt    <= 4'd0;
                        state  <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Synthesizable response-checking end of the two-input gate test flow: drives an exhaustive 4-vector sequence onto a 2-input combinational DUT (x, y), waits a settle window, samples the DUT output z, and compares it against a truth table given as a parameter.
- Reports a per-vector fail mask, an error count and pass/done status.
- Replaces hand-run stimulus/monitor checks with an on-chip, self-checking sequencer.

Parameters:
- SETTLE_CYCLES, 2, cycles each vector is held before z is sampled; legal range 1..15 (elaboration error otherwise).
- EXPECTED, 4'b1110, expected z indexed by {x,y}; bit[{x,y}] is the expected output. Default is the OR truth table.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  run request; sampled only in IDLE.
- z  input  1  DUT output under observation.
- x  output  1  DUT input A (registered).
- y  output  1  DUT input B (registered).
- busy  output  1  high from the cycle after start is accepted through the DONE cycle.
- done  output  1  one-cycle pulse at end of run.
- pass  output  1  valid from done onward; 1 iff all 4 vectors matched.
- err_count  output  3  number of mismatching vectors (0..4).
- fail_mask  output  4  bit[{x,y}] set if that vector mismatched.

Behaviour:
- Reset (rst=1 at a clk edge, any state): state=IDLE, x=0, y=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0, step=0, settle counter=0.
- Reset mid-run aborts immediately. No done pulse is produced and no partial results are kept.
- FSM states: IDLE, SETTLE, SAMPLE, DONE.
- Vector order (step 0..3), Gray order so only one input toggles per step: {x,y} = 00, 10, 11, 01.
- IDLE:
  - x=y=0.
  - On start=1: clear err_count, fail_mask and pass; drive step-0 vector; cnt=0; go to SETTLE.
- SETTLE:
  - Hold the vector; cnt increments each cycle.
  - When cnt==SETTLE_CYCLES-1, go to SAMPLE.
- SAMPLE:
  - Compare z against EXPECTED[{x,y}] at this clock edge.
  - On mismatch: err_count+=1 and set fail_mask[{x,y}].
  - An unknown z (X/Z) counts as a mismatch in simulation; the comparison uses case equality.
  - If step==3, go to DONE. Otherwise step+=1, drive the next vector, cnt=0, go to SETTLE.
- DONE:
  - done=1 for exactly one cycle.
  - pass = (err_count==0), computed after the final compare.
  - x=y=0, then go to IDLE.
- Latency: start accepted at edge T.
  - Vector k is driven in cycles T+1+k*(S+1) .. T+k*(S+1)+S+1, where S=SETTLE_CYCLES.
  - done is high in cycle T+1+4*(S+1). With S=2 this is T+13.
- busy is low in IDLE and high in SETTLE, SAMPLE and DONE.
- start is ignored while busy, including during the DONE cycle. A new run needs start=1 while in IDLE.
- Results persist after DONE:
  - pass, err_count and fail_mask hold until the next accepted start or reset.
  - done does not hold.
- err_count cannot wrap: the maximum is 4 and it fits in 3 bits.

Test Plan:
- Correct OR model on z, S=2, start pulse at T:
  - x/y toggles follow 00→10→11→01, each held 3 cycles.
  - done at T+13.
  - pass=1, err_count=0, fail_mask=0000.
- z tied to 0, OR EXPECTED:
  - err_count=3, fail_mask=4'b1110, pass=0.
  - done still at T+13.
- AND model as DUT with EXPECTED=4'b1110:
  - mismatches at {x,y}=10 and 01.
  - err_count=2, fail_mask=4'b0110, pass=0.
- Same AND model with EXPECTED=4'b1000 and SETTLE_CYCLES=1:
  - pass=1.
  - done at T+9.
- start held high or re-pulsed during a run; also a second run started after a failing run:
  - No restart mid-run.
  - The second run clears the old fail_mask/err_count on accept and reports its own result.
- rst asserted while step=2 (x=1,y=1):
  - Next cycle x=0, y=0, busy=0, err_count=0, fail_mask=0.
  - No done pulse.
  - A subsequent start completes normally.
